// File: rtl/vga_timing_gen.sv
// VGA timing source: divides the board clock down to the pixel rate, scans x/y, and registers
// sync, blank and colour to the DAC pins exactly one pixel period behind the x/y it exposes.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       frame_start,
  output logic       vga_clk,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]      h_cnt_q, h_cnt_d;
  logic [9:0]      v_cnt_q, v_cnt_d;
  logic            vga_clk_q, vga_clk_d;
  logic            frame_start_q, frame_start_d;
  logic            hs_q, vs_q, blank_n_q;
  logic [7:0]      r_q, g_q, b_q;

  logic pix_ce, h_last, v_last, hs_raw, vs_raw;

  assign pix_ce = (div_cnt_q == DivW'(CLK_DIV - 1));
  assign h_last = (h_cnt_q == 10'(HTotal - 1));
  assign v_last = (v_cnt_q == 10'(VTotal - 1));

  assign active = (h_cnt_q < 10'(H_ACTIVE)) && (v_cnt_q < 10'(V_ACTIVE));
  assign hs_raw = !((h_cnt_q >= 10'(H_ACTIVE + H_FP)) &&
                    (h_cnt_q <  10'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs_raw = !((v_cnt_q >= 10'(V_ACTIVE + V_FP)) &&
                    (v_cnt_q <  10'(V_ACTIVE + V_FP + V_SYNC)));

  always_comb begin
    div_cnt_d     = pix_ce ? '0 : div_cnt_q + DivW'(1);
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    if (pix_ce) begin
      h_cnt_d = h_last ? '0 : h_cnt_q + 10'd1;
      if (h_last) begin
        v_cnt_d = v_last ? '0 : v_cnt_q + 10'd1;
      end
    end
    // Registered from the next divider value so vga_clk tracks div_cnt without a lag cycle,
    // putting its rising edge mid-way through each stable output window.
    vga_clk_d     = (div_cnt_d >= DivW'(CLK_DIV / 2));
    frame_start_d = pix_ce && h_last && v_last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      vga_clk_q     <= 1'b0;
      frame_start_q <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      vga_clk_q     <= vga_clk_d;
      frame_start_q <= frame_start_d;
      if (pix_ce) begin
        hs_q      <= hs_raw;
        vs_q      <= vs_raw;
        blank_n_q <= active;
        r_q       <= active ? r_in : '0;
        g_q       <= active ? g_in : '0;
        b_q       <= active ? b_in : '0;
      end
    end
  end

  assign x           = h_cnt_q;
  assign y           = v_cnt_q;
  assign frame_start = frame_start_q;
  assign vga_clk     = vga_clk_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b0;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;

endmodule
